// File: rtl/vital_level_tracker.sv
// vital_level_tracker
//   Holds the saturating energy and stress levels that feed the physical
//   state controller. Controller requests (en_inc / en_dec / st_dec) are
//   applied once per prescaled tick. External stress events are applied
//   in the cycle they arrive. Each level is quantised into a 2-bit band
//   indicator with hysteresis so that the sleep/wake decisions downstream
//   do not chatter around a boundary.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   en_inc, en_dec    energy increase / decrease requests (tick-gated)
//   st_dec            stress decay request (tick-gated)
//   st_event          stressor pulse, one event per high cycle
//   freeze            holds the prescaler and all tick-based updates
//   energy_level      current energy (WIDTH bits)
//   stress_level      current stress (WIDTH bits)
//   energy_indicator  quantised energy band (0..3)
//   stress_indicator  quantised stress band (0..3)
//   tick              one-cycle update pulse
module vital_level_tracker #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE      = 16,
  parameter int ENERGY_INIT   = 192,
  parameter int EN_INC_STEP   = 2,
  parameter int EN_DEC_STEP   = 1,
  parameter int ST_DEC_STEP   = 1,
  parameter int ST_EVENT_STEP = 64,
  parameter int HYST          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_inc,
  input  logic             en_dec,
  input  logic             st_dec,
  input  logic             st_event,
  input  logic             freeze,
  output logic [WIDTH-1:0] energy_level,
  output logic [WIDTH-1:0] stress_level,
  output logic [1:0]       energy_indicator,
  output logic [1:0]       stress_indicator,
  output logic             tick
);

  localparam int PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW      = WIDTH + 2;
  localparam int QUARTER = 1 << (WIDTH - 2);

  typedef logic signed [SW-1:0] sval_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam sval_t         LEVEL_MAX  = sval_t'((1 << WIDTH) - 1);
  localparam sval_t         INC_S      = sval_t'(EN_INC_STEP);
  localparam sval_t         DEC_S      = sval_t'(EN_DEC_STEP);
  localparam sval_t         ST_DEC_S   = sval_t'(ST_DEC_STEP);
  localparam sval_t         ST_EVT_S   = sval_t'(ST_EVENT_STEP);

  // Saturate a signed working value back into the unsigned level range.
  function automatic logic [WIDTH-1:0] clamp_level(input sval_t v);
    if (v < 0)              return '0;
    else if (v > LEVEL_MAX) return '1;
    else                    return v[WIDTH-1:0];
  endfunction

  // Number of band boundaries k*QUARTER (k=1..3), lowered by hyst, that lvl reaches.
  function automatic logic [1:0] band_of(input int lvl, input int hyst);
    logic [1:0] n;
    n = '0;
    for (int k = 1; k <= 3; k++) begin
      if (lvl >= k * QUARTER - hyst) n = n + 2'd1;
    end
    return n;
  endfunction

  // Rise as soon as the up-band exceeds the current band; fall only once the
  // level has dropped HYST below the boundary. Multi-band moves take one step.
  function automatic logic [1:0] next_band(input logic [1:0] cur, input int lvl);
    logic [1:0] up;
    logic [1:0] dn;
    up = band_of(lvl, 0);
    dn = band_of(lvl, HYST);
    if (up > cur)      return up;
    else if (dn < cur) return dn;
    else               return cur;
  endfunction

  localparam logic [1:0] E_IND_INIT = band_of(ENERGY_INIT, 0);

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] energy_q, energy_d;
  logic [WIDTH-1:0] stress_q, stress_d;
  logic [1:0]       e_ind_q, e_ind_d;
  logic [1:0]       s_ind_q, s_ind_d;
  sval_t            e_sum, s_sum;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (!freeze) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    e_sum = $signed({2'b00, energy_q});
    if (tick_q && en_inc) e_sum = e_sum + INC_S;
    if (tick_q && en_dec) e_sum = e_sum - DEC_S;
    energy_d = clamp_level(e_sum);

    s_sum = $signed({2'b00, stress_q});
    if (st_event)         s_sum = s_sum + ST_EVT_S;
    if (tick_q && st_dec) s_sum = s_sum - ST_DEC_S;
    stress_d = clamp_level(s_sum);

    // Indicators follow the registered levels, hence one cycle of lag.
    e_ind_d = next_band(e_ind_q, int'(energy_q));
    s_ind_d = next_band(s_ind_q, int'(stress_q));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      tick_q   <= 1'b0;
      energy_q <= WIDTH'(ENERGY_INIT);
      stress_q <= '0;
      e_ind_q  <= E_IND_INIT;
      s_ind_q  <= 2'b00;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      energy_q <= energy_d;
      stress_q <= stress_d;
      e_ind_q  <= e_ind_d;
      s_ind_q  <= s_ind_d;
    end
  end

  assign energy_level     = energy_q;
  assign stress_level     = stress_q;
  assign energy_indicator = e_ind_q;
  assign stress_indicator = s_ind_q;
  assign tick             = tick_q;

endmodule

// File: tb/tb_vital_level_tracker.sv
// Directed bench for vital_level_tracker (WIDTH=8, PRESCALE=4, HYST=4).
module tb_vital_level_tracker;

  logic       clk;
  logic       rst_n;
  logic       en_inc, en_dec, st_dec, st_event, freeze;
  logic [7:0] energy_level, stress_level;
  logic [1:0] energy_indicator, stress_indicator;
  logic       tick;

  int n_checks = 0;
  int n_err    = 0;

  vital_level_tracker #(
    .WIDTH(8), .PRESCALE(4), .ENERGY_INIT(192), .EN_INC_STEP(2),
    .EN_DEC_STEP(1), .ST_DEC_STEP(1), .ST_EVENT_STEP(64), .HYST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .en_inc(en_inc), .en_dec(en_dec), .st_dec(st_dec),
    .st_event(st_event), .freeze(freeze),
    .energy_level(energy_level), .stress_level(stress_level),
    .energy_indicator(energy_indicator), .stress_indicator(stress_indicator),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    int         exp_s;
    logic [1:0] exp_si;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until tick is high (returns at once if it already is).
  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("tick_seen", 32'(tick), 1);
  endtask

  // Count edges until tick rises.
  task automatic count_to_tick(input string name, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 12);
    check(name, n, exp);
  endtask

  initial begin
    tbl[0] = '{1'b1,  64, 2'b00};
    tbl[1] = '{1'b0,  64, 2'b01};
    tbl[2] = '{1'b1, 128, 2'b01};
    tbl[3] = '{1'b0, 128, 2'b10};
    tbl[4] = '{1'b1, 192, 2'b10};
    tbl[5] = '{1'b0, 192, 2'b11};
    tbl[6] = '{1'b1, 255, 2'b11};
    tbl[7] = '{1'b1, 255, 2'b11};

    rst_n = 1'b0; en_inc = 1'b0; en_dec = 1'b0; st_dec = 1'b0;
    st_event = 1'b0; freeze = 1'b0;

    // Power-on reset values.
    #12;
    check("rst_energy", 32'(energy_level), 192);
    check("rst_stress", 32'(stress_level), 0);
    check("rst_e_ind", 32'(energy_indicator), 3);
    check("rst_s_ind", 32'(stress_indicator), 0);
    check("rst_tick", 32'(tick), 0);
    #11;
    rst_n = 1'b1;
    count_to_tick("first_tick_latency", 4);

    // Energy decay through the 192 boundary, hysteresis at 188.
    en_dec = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_tick();
      step();
      check("decay_energy", 32'(energy_level), 32'(192 - i));
      if (i == 4) begin
        step();
        check("ind_hold_188", 32'(energy_indicator), 3);
      end
    end
    check("ind_lag_187", 32'(energy_indicator), 3);
    step();
    check("ind_drop_187", 32'(energy_indicator), 2);

    // Climb back above 192.
    en_dec = 1'b0;
    en_inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      step();
      check("climb_energy", 32'(energy_level), 32'(187 + 2 * i));
      if (i == 2) check("ind_stay_191", 32'(energy_indicator), 2);
    end
    check("ind_lag_193", 32'(energy_indicator), 2);
    step();
    check("ind_rise_193", 32'(energy_indicator), 3);

    // Both requests on one tick: net +1.
    en_dec = 1'b1;
    wait_tick();
    step();
    check("net_inc_dec", 32'(energy_level), 194);
    en_dec = 1'b0;

    // Upper saturation.
    for (int i = 0; i < 30; i++) begin
      wait_tick();
      step();
    end
    check("energy_254", 32'(energy_level), 254);
    wait_tick();
    step();
    check("energy_sat_255", 32'(energy_level), 255);
    wait_tick();
    step();
    check("energy_stay_255", 32'(energy_level), 255);

    // Freeze (prescaler held at 1): stress events still apply, energy holds.
    freeze = 1'b1;
    en_inc = 1'b0;
    en_dec = 1'b1;
    for (int i = 0; i < 8; i++) begin
      st_event = tbl[i].ev;
      step();
      check("tbl_stress", 32'(stress_level), 32'(tbl[i].exp_s));
      check("tbl_s_ind", 32'(stress_indicator), 32'(tbl[i].exp_si));
      check("tbl_energy_frozen", 32'(energy_level), 255);
      check("tbl_tick_frozen", 32'(tick), 0);
    end
    st_event = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("frozen_tick", 32'(tick), 0);
    end
    check("frozen_energy", 32'(energy_level), 255);
    freeze = 1'b0;
    count_to_tick("resume_tick_latency", 3);
    step();
    check("post_freeze_dec", 32'(energy_level), 254);
    en_dec = 1'b0;

    // Mid-simulation asynchronous reset.
    rst_n = 1'b0;
    #1;
    check("mid_rst_energy", 32'(energy_level), 192);
    check("mid_rst_stress", 32'(stress_level), 0);
    check("mid_rst_e_ind", 32'(energy_indicator), 3);
    check("mid_rst_s_ind", 32'(stress_indicator), 0);
    check("mid_rst_tick", 32'(tick), 0);
    step();
    step();
    rst_n = 1'b1;
    count_to_tick("mid_rst_tick_latency", 4);

    // Stress floor, event, decay and simultaneous event+decay.
    st_dec = 1'b1;
    step();
    check("stress_floor_0", 32'(stress_level), 0);
    st_event = 1'b1;
    step();
    st_event = 1'b0;
    check("stress_event_64", 32'(stress_level), 64);
    step();
    check("s_ind_01", 32'(stress_indicator), 1);
    for (int i = 0; i < 54; i++) begin
      wait_tick();
      step();
    end
    check("stress_decay_10", 32'(stress_level), 10);
    wait_tick();
    st_event = 1'b1;
    step();
    st_event = 1'b0;
    check("stress_evt_and_dec", 32'(stress_level), 73);
    step();
    check("s_ind_73", 32'(stress_indicator), 1);
    st_event = 1'b1;
    step();
    st_event = 1'b0;
    check("stress_137", 32'(stress_level), 137);
    for (int i = 0; i < 37; i++) begin
      wait_tick();
      step();
    end
    check("stress_100", 32'(stress_level), 100);
    check("s_ind_100", 32'(stress_indicator), 1);
    st_dec = 1'b0;
    st_event = 1'b1;
    step();
    st_event = 1'b0;
    check("stress_164", 32'(stress_level), 164);
    check("s_ind_lag_164", 32'(stress_indicator), 1);
    step();
    check("s_ind_jump_164", 32'(stress_indicator), 2);
    step();
    check("s_ind_hold_164", 32'(stress_indicator), 2);

    // Energy lower saturation.
    en_dec = 1'b1;
    for (int i = 0; i < 192; i++) begin
      wait_tick();
      step();
    end
    check("energy_floor_0", 32'(energy_level), 0);
    step();
    check("e_ind_00", 32'(energy_indicator), 0);
    wait_tick();
    step();
    check("energy_stay_0", 32'(energy_level), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
